// File: rtl/clz_arbiter_if.sv
// Request/response bundle between the requesters and the shared CLZ unit.
// The master side issues operands; the slave side (clz_arbiter) grants them and returns counts.
interface clz_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [5:0]         rsp_count;
  logic               busy;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  rsp_valid,
    input  rsp_count,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output rsp_valid,
    output rsp_count,
    output busy
  );
endinterface

// File: rtl/clz_arbiter.sv
// Round-robin arbiter that shares one count-leading-zeros datapath between NREQ
// requesters through a two-stage pipeline, routing each count back to its issuer.
module clz_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic         clk,
  input  logic         resetn,
  clz_arbiter_if.slave bus
);

  generate
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("clz_arbiter: NREQ must be in 2..4");
    end
    if (IDW != $clog2(NREQ)) begin : g_bad_idw
      $error("clz_arbiter: IDW must equal clog2(NREQ)");
    end
  endgenerate

  // Requester index arithmetic modulo NREQ; base is always < NREQ, off <= NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum + 0;
    end
    return sum[IDW-1:0];
  endfunction

  // Binary-search leading-zero count; a zero operand reports the full width.
  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [31:0] x;
    logic [4:0]  n;
    x = v;
    n = 5'd0;
    if (x[31:16] == 16'd0) begin
      n[4] = 1'b1;
      x    = {x[15:0], 16'd0};
    end else begin
      n[4] = 1'b0;
    end
    if (x[31:24] == 8'd0) begin
      n[3] = 1'b1;
      x    = {x[23:0], 8'd0};
    end else begin
      n[3] = 1'b0;
    end
    if (x[31:28] == 4'd0) begin
      n[2] = 1'b1;
      x    = {x[27:0], 4'd0};
    end else begin
      n[2] = 1'b0;
    end
    if (x[31:30] == 2'd0) begin
      n[1] = 1'b1;
      x    = {x[29:0], 2'd0};
    end else begin
      n[1] = 1'b0;
    end
    if (x[31] == 1'b0) begin
      n[0] = 1'b1;
    end else begin
      n[0] = 1'b0;
    end
    if (v == 32'd0) begin
      return 6'd32;
    end else begin
      return {1'b0, n};
    end
  endfunction

  logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic            s1_valid_q,  s1_valid_d;
  logic [IDW-1:0]  s1_id_q,     s1_id_d;
  logic [31:0]     s1_op_q,     s1_op_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [5:0]      s2_cnt_q,    s2_cnt_d;
  logic            busy_q,      busy_d;

  logic            grant_vld_s;
  logic [IDW-1:0]  grant_id_s;
  logic [NREQ-1:0] grant_oh_s;
  logic [NREQ-1:0] s1_oh_s;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld_s && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = wrap_add(rr_ptr_q, k);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // One-hot forms of the current grant and of the stage-1 owner.
  always_comb begin
    grant_oh_s = '0;
    s1_oh_s    = '0;
    if (grant_vld_s) begin
      grant_oh_s[grant_id_s] = 1'b1;
    end else begin
      grant_oh_s = '0;
    end
    if (s1_valid_q) begin
      s1_oh_s[s1_id_q] = 1'b1;
    end else begin
      s1_oh_s = '0;
    end
  end

  // Grant is suppressed while reset is held so nothing is handshaken mid-reset.
  assign bus.req_ready = resetn ? grant_oh_s : '0;

  // Pipeline next state: stage 1 captures the granted operand, stage 2 the count.
  always_comb begin
    s1_valid_d  = grant_vld_s;
    s1_id_d     = s1_id_q;
    s1_op_d     = s1_op_q;
    rr_ptr_d    = rr_ptr_q;
    s2_cnt_d    = s2_cnt_q;
    rsp_valid_d = s1_oh_s;
    busy_d      = grant_vld_s | s1_valid_q;
    if (grant_vld_s) begin
      s1_id_d  = grant_id_s;
      s1_op_d  = bus.req_data[{grant_id_s, 5'd0} +: 32];
      rr_ptr_d = wrap_add(grant_id_s, 1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (s1_valid_q) begin
      s2_cnt_d = clz32(s1_op_q);
    end else begin
      s2_cnt_d = s2_cnt_q;
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_op_q     <= 32'd0;
      rsp_valid_q <= '0;
      s2_cnt_q    <= 6'd0;
      busy_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_op_q     <= s1_op_d;
      rsp_valid_q <= rsp_valid_d;
      s2_cnt_q    <= s2_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_count = s2_cnt_q;
  assign bus.busy      = busy_q;

endmodule
